// File: rtl/fir_cmplx_decim.sv
// fir_cmplx_decim: complex FIR with decimation, one tap per cycle, FIFO-style handshakes on both sides
module fir_cmplx_decim #(
  parameter int TAPS = 20,
  parameter int DATA_WIDTH = 32,
  parameter int DECIM = 1,
  parameter int FRAC_BITS = 10,
  parameter logic [0:TAPS-1][DATA_WIDTH-1:0] h_real = '0,
  parameter logic [0:TAPS-1][DATA_WIDTH-1:0] h_imag = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] x_real_in,
  input  logic [DATA_WIDTH-1:0] x_imag_in,
  input  logic                  x_real_empty,
  input  logic                  x_imag_empty,
  output logic                  x_real_rd_en,
  output logic                  x_imag_rd_en,
  output logic [DATA_WIDTH-1:0] y_real_out,
  output logic [DATA_WIDTH-1:0] y_imag_out,
  input  logic                  y_real_full,
  input  logic                  y_imag_full,
  output logic                  y_real_wr_en,
  output logic                  y_imag_wr_en
);
  localparam int AW = 2 * DATA_WIDTH;
  localparam int KW = TAPS > 1 ? $clog2(TAPS) : 1;
  localparam int CW = $clog2(DECIM + 1);
  typedef enum logic [1:0] {S_READ, S_MAC, S_WRITE} state_t;
  state_t r_state, w_next;
  logic [DATA_WIDTH-1:0] r_xr [TAPS];
  logic [DATA_WIDTH-1:0] r_xi [TAPS];
  logic [CW-1:0] r_cnt, w_cnt_inc;
  logic [KW-1:0] r_k;
  logic signed [AW-1:0] r_acc_r, r_acc_i, w_hr, w_hi, w_xr, w_xi, w_sum_r, w_sum_i;
  logic w_rd, w_wr, w_last_pop, w_last_tap;
  // strobes are gated by rst so nothing pops or pushes while reset is held
  assign w_rd = rst && r_state == S_READ && !x_real_empty && !x_imag_empty;
  assign w_wr = rst && r_state == S_WRITE && !y_real_full && !y_imag_full;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_last_pop = w_cnt_inc == CW'(DECIM);
  assign w_last_tap = r_k == KW'(TAPS - 1);
  assign w_hr = AW'(signed'(h_real[r_k]));
  assign w_hi = AW'(signed'(h_imag[r_k]));
  assign w_xr = AW'(signed'(r_xr[r_k]));
  assign w_xi = AW'(signed'(r_xi[r_k]));
  assign w_sum_r = r_acc_r + w_hr * w_xr - w_hi * w_xi;
  assign w_sum_i = r_acc_i + w_hr * w_xi + w_hi * w_xr;
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_READ;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state == S_READ ? (w_rd && w_last_pop ? S_MAC : S_READ) :
             r_state == S_MAC  ? (w_last_tap ? S_WRITE : S_MAC) :
             w_wr ? S_READ : S_WRITE;
  end
  always_comb begin
    x_real_rd_en = w_rd;
    x_imag_rd_en = w_rd;
    y_real_wr_en = w_wr;
    y_imag_wr_en = w_wr;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) begin
        r_xr[i] <= '0;
        r_xi[i] <= '0;
      end
      r_cnt <= '0;
      r_k <= '0;
      r_acc_r <= '0;
      r_acc_i <= '0;
      y_real_out <= '0;
      y_imag_out <= '0;
    end else begin
      if (w_rd) begin
        r_xr[0] <= x_real_in;
        r_xi[0] <= x_imag_in;
        for (int i = 1; i < TAPS; i++) begin
          r_xr[i] <= r_xr[i-1];
          r_xi[i] <= r_xi[i-1];
        end
        r_cnt <= w_last_pop ? '0 : w_cnt_inc;
      end
      // the last tap folds straight into the output; accumulators restart at zero
      if (r_state == S_MAC) begin
        r_k <= w_last_tap ? '0 : r_k + 1'b1;
        r_acc_r <= w_last_tap ? '0 : w_sum_r;
        r_acc_i <= w_last_tap ? '0 : w_sum_i;
        if (w_last_tap) begin
          y_real_out <= DATA_WIDTH'(w_sum_r >>> FRAC_BITS);
          y_imag_out <= DATA_WIDTH'(w_sum_i >>> FRAC_BITS);
        end
      end
    end
  end
endmodule

// File: tb/tb_fir_cmplx_decim.sv
// tb_fir_cmplx_decim: six differently parameterised instances driven from FIFO models, scoreboard checked
module tb_fir_cmplx_decim;
  localparam int NI = 6, T = 4, W = 32, QD = 1024;
  localparam logic [0:NI-1][0:T-1][W-1:0] HR = {
    {32'd1, 32'd2, 32'd3, 32'd4},
    {32'd0, 32'd0, 32'd0, 32'd0},
    {32'd1, 32'd1, 32'd0, 32'd0},
    {32'd512, 32'd0, 32'd0, 32'd0},
    {32'd1024, 32'd0, 32'd0, 32'd0},
    {32'd7, -32'd300, 32'd55, 32'd1000}};
  localparam logic [0:NI-1][0:T-1][W-1:0] HI = {
    {32'd0, 32'd0, 32'd0, 32'd0},
    {32'd1, 32'd0, 32'd0, 32'd0},
    {32'd0, 32'd0, 32'd0, 32'd0},
    {32'd0, 32'd0, 32'd0, 32'd0},
    {32'd0, 32'd0, 32'd0, 32'd0},
    {-32'd9, 32'd123, -32'd4000, 32'd2}};
  localparam logic [0:NI-1][3:0] DEC = {4'd1, 4'd1, 4'd2, 4'd1, 4'd1, 4'd3};
  localparam logic [0:NI-1][3:0] FR = {4'd0, 4'd0, 4'd0, 4'd10, 4'd10, 4'd4};
  logic clk = 0, rst;
  logic [NI-1:0] full_r, full_i, st_r, st_i;
  wire [NI-1:0] xe_r, xe_i, rd_r, rd_i, wr_r, wr_i, pend;
  wire [NI-1:0][W-1:0] xr_in, xi_in, yr, yi;
  logic [W-1:0] fr [NI][QD];
  logic [W-1:0] fi [NI][QD];
  logic [W-1:0] er [NI][QD];
  logic [W-1:0] ei [NI][QD];
  int mr [NI][QD];
  int mi [NI][QD];
  int fw [NI];
  int ew [NI];
  int erd [NI];
  int mn [NI];
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < NI; g++) begin : gi
    int rd = 0;
    assign xe_r[g] = (rd == fw[g]) || st_r[g];
    assign xe_i[g] = (rd == fw[g]) || st_i[g];
    assign xr_in[g] = fr[g][rd % QD];
    assign xi_in[g] = fi[g][rd % QD];
    assign pend[g] = rd != fw[g];
    always @(posedge clk) if (rd_r[g]) rd <= rd + 1;
    fir_cmplx_decim #(.TAPS(T), .DATA_WIDTH(W), .DECIM(int'(DEC[g])), .FRAC_BITS(int'(FR[g])),
                      .h_real(HR[g]), .h_imag(HI[g])) dut (
      .clk(clk), .rst(rst),
      .x_real_in(xr_in[g]), .x_imag_in(xi_in[g]),
      .x_real_empty(xe_r[g]), .x_imag_empty(xe_i[g]),
      .x_real_rd_en(rd_r[g]), .x_imag_rd_en(rd_i[g]),
      .y_real_out(yr[g]), .y_imag_out(yi[g]),
      .y_real_full(full_r[g]), .y_imag_full(full_i[g]),
      .y_real_wr_en(wr_r[g]), .y_imag_wr_en(wr_i[g]));
  end
  task automatic check(string nm, int g, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, g, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_y(int g, int y_r, int y_i);
    er[g][ew[g] % QD] = y_r;
    ei[g][ew[g] % QD] = y_i;
    ew[g]++;
  endtask
  // reference: plain convolution over every sample since reset, one output per DECIM samples
  task automatic push(int g, int x_r, int x_i, bit m);
    longint ar, ai, hr, hi, vr, vi, sr, si;
    fr[g][fw[g] % QD] = x_r;
    fi[g][fw[g] % QD] = x_i;
    mr[g][mn[g]] = x_r;
    mi[g][mn[g]] = x_i;
    mn[g]++;
    if (m && mn[g] % int'(DEC[g]) == 0) begin
      ar = 0;
      ai = 0;
      for (int k = 0; k < T; k++) begin
        if (mn[g] - 1 - k >= 0) begin
          hr = longint'($signed(HR[g][k]));
          hi = longint'($signed(HI[g][k]));
          vr = mr[g][mn[g]-1-k];
          vi = mi[g][mn[g]-1-k];
          ar += hr * vr - hi * vi;
          ai += hr * vi + hi * vr;
        end
      end
      sr = ar >>> int'(FR[g]);
      si = ai >>> int'(FR[g]);
      expect_y(g, int'(sr[31:0]), int'(si[31:0]));
    end
    fw[g]++;
  endtask
  function automatic bit sb_empty();
    for (int g = 0; g < NI; g++) if (erd[g] != ew[g]) return 0;
    return 1;
  endfunction
  task automatic drain();
    int n = 0;
    while ((pend != '0 || !sb_empty()) && n < 3000) begin
      tick();
      n++;
    end
    check("drain_done", 0, 64'(n < 3000), 1);
  endtask
  task automatic wait_rd(int g);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rd_r[g] && n < 100);
    check("pop_seen", g, 64'(rd_r[g]), 1);
  endtask
  task automatic impulse();
    int n = 0;
    push(0, 1, 0, 0);
    expect_y(0, 1, 0);
    wait_rd(0);
    do begin
      @(negedge clk);
      n++;
    end while (!wr_r[0] && n < 40);
    check("latency", 0, 64'(n), T + 1);
    tick();
    push(0, 0, 0, 0); expect_y(0, 2, 0);
    push(0, 0, 0, 0); expect_y(0, 3, 0);
    push(0, 0, 0, 0); expect_y(0, 4, 0);
    push(0, 0, 0, 0); expect_y(0, 0, 0);
    drain();
  endtask
  // monitor: protocol on every strobe, data popped from the scoreboard on every write
  initial begin
    for (int g = 0; g < NI; g++) erd[g] = 0;
    forever begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        if (rd_r[g] | rd_i[g] | wr_r[g] | wr_i[g]) begin
          check("strobe_pairs", g, {rd_r[g], wr_r[g]}, {rd_i[g], wr_i[g]});
          check("rd_wr_excl", g, 64'(rd_r[g] & wr_r[g]), 0);
        end
        if (wr_r[g]) begin
          if (erd[g] == ew[g]) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write[%0d]: y=%0h/%0h", g, yr[g], yi[g]);
          end else begin
            check("y_out", g, {yr[g], yi[g]}, {er[g][erd[g] % QD], ei[g][erd[g] % QD]});
            erd[g]++;
          end
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic bad;
    rst = 0;
    full_r = '0; full_i = '0; st_r = '0; st_i = '0;
    for (int g = 0; g < NI; g++) begin
      fw[g] = 0; ew[g] = 0; mn[g] = 0;
    end
    tick();
    push(5, 11, -13, 1);
    repeat (2) tick();
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check("rst_y", g, {yr[g], yi[g]}, 0);
      check("rst_strobes", g, {rd_r[g], rd_i[g], wr_r[g], wr_i[g]}, 0);
    end
    tick();
    rst = 1;
    impulse();
    push(1, 3, 5, 0); expect_y(1, -5, 3);
    push(2, 1, 0, 0); push(2, 2, 0, 0); expect_y(2, 3, 0);
    push(2, 3, 0, 0); push(2, 4, 0, 0); expect_y(2, 7, 0);
    push(3, -3, 0, 0); expect_y(3, -2, 0);
    push(4, -3, 0, 0); expect_y(4, -3, 0);
    drain();
    st_i[0] = 1;
    push(0, 5, 6, 1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      bad |= rd_r[0] | rd_i[0];
    end
    check("one_empty_hold", 0, 64'(bad), 0);
    tick();
    st_i[0] = 0;
    drain();
    full_i[0] = 1;
    push(0, 1000, -77, 1);
    push(0, -4, 250, 1);
    repeat (8) tick();
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      bad |= wr_r[0] | wr_i[0] | rd_r[0] | rd_i[0] |
             (yr[0] != er[0][erd[0] % QD]) | (yi[0] != ei[0][erd[0] % QD]);
    end
    check("backpressure_hold", 0, 64'(bad), 0);
    tick();
    full_i[0] = 0;
    drain();
    push(0, 7, 9, 0);
    wait_rd(0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    repeat (2) tick();
    @(negedge clk);
    check("mid_mac_rst_y", 0, {yr[0], yi[0]}, 0);
    check("mid_mac_rst_strobes", 0, {rd_r[0], wr_r[0]}, 0);
    tick();
    rst = 1;
    for (int g = 0; g < NI; g++) begin
      mn[g] = 0;
      ew[g] = erd[g];
    end
    impulse();
    repeat (600) begin
      tick();
      for (int g = 0; g < NI; g++) begin
        full_r[g] = $urandom_range(0, 3) == 0;
        full_i[g] = $urandom_range(0, 3) == 0;
        st_r[g] = $urandom_range(0, 7) == 0;
        st_i[g] = $urandom_range(0, 7) == 0;
      end
      if ($urandom_range(0, 2) == 0) push(int'($urandom_range(0, NI - 1)), int'($urandom), int'($urandom), 1);
    end
    full_r = '0; full_i = '0; st_r = '0; st_i = '0;
    drain();
    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
